// File: rtl/dbg_guv_ctl.sv
// Inline AXI-Stream debug governor: pause, drop, log and inject on a user stream,
// configured through shadow registers that a commit command copies atomically.
module dbg_guv_ctl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEST_WIDTH = 16,
    parameter int unsigned ID_WIDTH   = 16,
    parameter int unsigned CNT_SIZE   = 16,
    parameter logic [7:0]  GUV_ADDR   = 8'd0
) (
    input  logic                                                         clk,
    input  logic                                                         rst,
    input  logic [DATA_WIDTH-1:0]                                        cmd_TDATA,
    input  logic                                                         cmd_TVALID,
    output logic                                                         cmd_TREADY,
    input  logic [DATA_WIDTH-1:0]                                        in_TDATA,
    input  logic [DATA_WIDTH/8-1:0]                                      in_TKEEP,
    input  logic [DEST_WIDTH-1:0]                                        in_TDEST,
    input  logic [ID_WIDTH-1:0]                                          in_TID,
    input  logic                                                         in_TLAST,
    input  logic                                                         in_TVALID,
    output logic                                                         in_TREADY,
    output logic [DATA_WIDTH-1:0]                                        out_TDATA,
    output logic [DATA_WIDTH/8-1:0]                                      out_TKEEP,
    output logic [DEST_WIDTH-1:0]                                        out_TDEST,
    output logic [ID_WIDTH-1:0]                                          out_TID,
    output logic                                                         out_TLAST,
    output logic                                                         out_TVALID,
    input  logic                                                         out_TREADY,
    output logic [DATA_WIDTH+DATA_WIDTH/8+1+DEST_WIDTH+ID_WIDTH-1:0]     log_catted_TDATA,
    output logic                                                         log_catted_TVALID,
    input  logic                                                         log_catted_TREADY,
    output logic                                                         log_catted_TLAST
);

    localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

    localparam logic [3:0] REG_DROP_CNT  = 4'd0;
    localparam logic [3:0] REG_LOG_CNT   = 4'd1;
    localparam logic [3:0] REG_INJ_DATA  = 4'd2;
    localparam logic [3:0] REG_INJ_VALID = 4'd3;
    localparam logic [3:0] REG_INJ_LAST  = 4'd4;
    localparam logic [3:0] REG_INJ_KEEP  = 4'd5;
    localparam logic [3:0] REG_INJ_DEST  = 4'd6;
    localparam logic [3:0] REG_INJ_ID    = 4'd7;
    localparam logic [3:0] REG_PAUSE     = 4'd8;
    localparam logic [3:0] REG_KEEP_DROP = 4'd9;
    localparam logic [3:0] REG_KEEP_LOG  = 4'd10;
    localparam logic [3:0] REG_COMMIT    = 4'd15;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_VAL  = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] reg_sel, reg_sel_nxt;
    logic       match, match_nxt;
    logic       commit_c, wr_en_c;

    logic                  cmd_hs, hdr_match;
    logic [3:0]            hdr_reg;

    logic [CNT_SIZE-1:0]   sh_drop_cnt, sh_log_cnt;
    logic [DATA_WIDTH-1:0] sh_inj_data;
    logic [KEEP_WIDTH-1:0] sh_inj_keep;
    logic [DEST_WIDTH-1:0] sh_inj_dest;
    logic [ID_WIDTH-1:0]   sh_inj_id;
    logic                  sh_inj_valid, sh_inj_last;
    logic                  sh_pause, sh_keep_drop, sh_keep_log;

    logic [CNT_SIZE-1:0]   act_drop_cnt, act_log_cnt;
    logic [DATA_WIDTH-1:0] act_inj_data;
    logic [KEEP_WIDTH-1:0] act_inj_keep;
    logic [DEST_WIDTH-1:0] act_inj_dest;
    logic [ID_WIDTH-1:0]   act_inj_id;
    logic                  act_inj_last, inj_pending;
    logic                  act_pause, act_keep_drop, act_keep_log;

    logic drop_act, log_act, in_hs, inj_hs;

    assign cmd_hs    = cmd_TVALID & cmd_TREADY;
    assign hdr_match = (cmd_TDATA[15:8] == GUV_ADDR);
    assign hdr_reg   = cmd_TDATA[3:0];

    // Command decoder state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            reg_sel    <= 4'd0;
            match      <= 1'b0;
            cmd_TREADY <= 1'b0;
        end else begin
            state      <= state_nxt;
            reg_sel    <= reg_sel_nxt;
            match      <= match_nxt;
            cmd_TREADY <= 1'b1;
        end
    end

    // Header/value sequencing; commit headers complete without a value flit
    always_comb begin
        state_nxt   = state;
        reg_sel_nxt = reg_sel;
        match_nxt   = match;
        commit_c    = 1'b0;
        wr_en_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_hs) begin
                    if (hdr_reg == REG_COMMIT) begin
                        commit_c = hdr_match;
                    end else begin
                        reg_sel_nxt = hdr_reg;
                        match_nxt   = hdr_match;
                        state_nxt   = ST_VAL;
                    end
                end
            end
            ST_VAL: begin
                if (cmd_hs) begin
                    wr_en_c   = match;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Shadow registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_drop_cnt  <= '0;
            sh_log_cnt   <= '0;
            sh_inj_data  <= '0;
            sh_inj_keep  <= '0;
            sh_inj_dest  <= '0;
            sh_inj_id    <= '0;
            sh_inj_valid <= 1'b0;
            sh_inj_last  <= 1'b0;
            sh_pause     <= 1'b0;
            sh_keep_drop <= 1'b0;
            sh_keep_log  <= 1'b0;
        end else if (wr_en_c) begin
            case (reg_sel)
                REG_DROP_CNT:  sh_drop_cnt  <= CNT_SIZE'(cmd_TDATA);
                REG_LOG_CNT:   sh_log_cnt   <= CNT_SIZE'(cmd_TDATA);
                REG_INJ_DATA:  sh_inj_data  <= cmd_TDATA;
                REG_INJ_VALID: sh_inj_valid <= cmd_TDATA[0];
                REG_INJ_LAST:  sh_inj_last  <= cmd_TDATA[0];
                REG_INJ_KEEP:  sh_inj_keep  <= KEEP_WIDTH'(cmd_TDATA);
                REG_INJ_DEST:  sh_inj_dest  <= DEST_WIDTH'(cmd_TDATA);
                REG_INJ_ID:    sh_inj_id    <= ID_WIDTH'(cmd_TDATA);
                REG_PAUSE:     sh_pause     <= cmd_TDATA[0];
                REG_KEEP_DROP: sh_keep_drop <= cmd_TDATA[0];
                REG_KEEP_LOG:  sh_keep_log  <= cmd_TDATA[0];
                default: ;
            endcase
        end else if (commit_c && !inj_pending && sh_inj_valid) begin
            sh_inj_valid <= 1'b0;
        end
    end

    assign in_hs  = in_TVALID & in_TREADY;
    assign inj_hs = inj_pending & out_TREADY;

    // Active registers; a commit wins over a same-cycle counter decrement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_drop_cnt  <= '0;
            act_log_cnt   <= '0;
            act_inj_data  <= '0;
            act_inj_keep  <= '0;
            act_inj_dest  <= '0;
            act_inj_id    <= '0;
            act_inj_last  <= 1'b0;
            inj_pending   <= 1'b0;
            act_pause     <= 1'b0;
            act_keep_drop <= 1'b0;
            act_keep_log  <= 1'b0;
        end else begin
            if (commit_c) begin
                act_drop_cnt <= sh_drop_cnt;
                act_log_cnt  <= sh_log_cnt;
            end else if (in_hs) begin
                if (act_drop_cnt != '0) act_drop_cnt <= act_drop_cnt - CNT_SIZE'(1);
                if (act_log_cnt != '0)  act_log_cnt  <= act_log_cnt - CNT_SIZE'(1);
            end

            if (inj_hs) inj_pending <= 1'b0;

            if (commit_c) begin
                act_pause     <= sh_pause;
                act_keep_drop <= sh_keep_drop;
                act_keep_log  <= sh_keep_log;
                // A still-pending injection keeps its payload; the shadow copy waits
                if (!inj_pending) begin
                    act_inj_data <= sh_inj_data;
                    act_inj_keep <= sh_inj_keep;
                    act_inj_dest <= sh_inj_dest;
                    act_inj_id   <= sh_inj_id;
                    act_inj_last <= sh_inj_last;
                    inj_pending  <= sh_inj_valid;
                end
            end
        end
    end

    assign drop_act = act_keep_drop | (act_drop_cnt != '0);
    assign log_act  = act_keep_log  | (act_log_cnt  != '0);

    // Zero-latency datapath: injection, then pause, then pass/drop/log
    always_comb begin
        in_TREADY         = 1'b0;
        out_TVALID        = 1'b0;
        log_catted_TVALID = 1'b0;
        out_TDATA         = in_TDATA;
        out_TKEEP         = in_TKEEP;
        out_TDEST         = in_TDEST;
        out_TID           = in_TID;
        out_TLAST         = in_TLAST;
        if (inj_pending) begin
            out_TDATA  = act_inj_data;
            out_TKEEP  = act_inj_keep;
            out_TDEST  = act_inj_dest;
            out_TID    = act_inj_id;
            out_TLAST  = act_inj_last;
            out_TVALID = 1'b1;
        end else if (!act_pause) begin
            in_TREADY         = (drop_act | out_TREADY) & (~log_act | log_catted_TREADY);
            out_TVALID        = in_TVALID & ~drop_act & (~log_act | log_catted_TREADY);
            log_catted_TVALID = in_TVALID & log_act & (drop_act | out_TREADY);
        end
    end

    assign log_catted_TDATA = {in_TDATA, in_TKEEP, in_TLAST, in_TDEST, in_TID};
    assign log_catted_TLAST = in_TLAST;

endmodule

// File: tb/tb_dbg_guv_ctl.sv
// Randomized scoreboard bench for dbg_guv_ctl against a flit-fate reference model.
module tb_dbg_guv_ctl;

    localparam int unsigned DW    = 32;
    localparam int unsigned KW    = DW / 8;
    localparam int unsigned DESTW = 16;
    localparam int unsigned IDW   = 16;
    localparam int unsigned CW    = 16;
    localparam int unsigned LW    = DW + KW + 1 + DESTW + IDW;
    localparam logic [7:0]  ADDR  = 8'h5A;

    typedef struct packed {
        logic [DW-1:0]    data;
        logic [KW-1:0]    keep;
        logic             last;
        logic [DESTW-1:0] dest;
        logic [IDW-1:0]   id;
    } flit_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [DW-1:0]    cmd_TDATA;
    logic             cmd_TVALID, cmd_TREADY;
    logic [DW-1:0]    in_TDATA, out_TDATA;
    logic [KW-1:0]    in_TKEEP, out_TKEEP;
    logic [DESTW-1:0] in_TDEST, out_TDEST;
    logic [IDW-1:0]   in_TID, out_TID;
    logic             in_TLAST, in_TVALID, in_TREADY;
    logic             out_TLAST, out_TVALID, out_TREADY;
    logic [LW-1:0]    log_catted_TDATA;
    logic             log_catted_TVALID, log_catted_TREADY, log_catted_TLAST;

    always #5 clk = ~clk;

    dbg_guv_ctl #(
        .DATA_WIDTH(DW), .DEST_WIDTH(DESTW), .ID_WIDTH(IDW), .CNT_SIZE(CW), .GUV_ADDR(ADDR)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_TDATA(cmd_TDATA), .cmd_TVALID(cmd_TVALID), .cmd_TREADY(cmd_TREADY),
        .in_TDATA(in_TDATA), .in_TKEEP(in_TKEEP), .in_TDEST(in_TDEST), .in_TID(in_TID),
        .in_TLAST(in_TLAST), .in_TVALID(in_TVALID), .in_TREADY(in_TREADY),
        .out_TDATA(out_TDATA), .out_TKEEP(out_TKEEP), .out_TDEST(out_TDEST), .out_TID(out_TID),
        .out_TLAST(out_TLAST), .out_TVALID(out_TVALID), .out_TREADY(out_TREADY),
        .log_catted_TDATA(log_catted_TDATA), .log_catted_TVALID(log_catted_TVALID),
        .log_catted_TREADY(log_catted_TREADY), .log_catted_TLAST(log_catted_TLAST)
    );

    // Reference model: shadow/active configuration and expected output streams
    logic [CW-1:0] sh_drop, sh_log, a_drop, a_log;
    flit_t         sh_inj, a_inj;
    logic          sh_inj_v, sh_pause, sh_kd, sh_kl;
    logic          a_pause, a_kd, a_kl, m_pending;
    logic          m_expect_val, m_match, m_cmd_rdy;
    logic [3:0]    m_reg;
    flit_t         exp_out[$];
    flit_t         exp_log[$];
    flit_t         mon_e;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sh_drop = '0; sh_log = '0; a_drop = '0; a_log = '0;
        sh_inj = '0; a_inj = '0;
        sh_inj_v = 0; sh_pause = 0; sh_kd = 0; sh_kl = 0;
        a_pause = 0; a_kd = 0; a_kl = 0; m_pending = 0;
        m_expect_val = 0; m_match = 0; m_reg = '0; m_cmd_rdy = 0;
        exp_out.delete();
        exp_log.delete();
    endtask

    function automatic flit_t mk(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                                 input logic [DESTW-1:0] de, input logic [IDW-1:0] i);
        flit_t f;
        f.data = d; f.keep = k; f.last = l; f.dest = de; f.id = i;
        return f;
    endfunction

    function automatic logic [DW-1:0] hdr(input logic [7:0] a, input logic [3:0] r);
        logic [DW-1:0] h;
        h = DW'($urandom);
        h[15:8] = a;
        h[3:0]  = r;
        return h;
    endfunction

    task automatic shadow_write(input logic [3:0] r, input logic [DW-1:0] v);
        case (r)
            4'd0:  sh_drop     = CW'(v);
            4'd1:  sh_log      = CW'(v);
            4'd2:  sh_inj.data = v;
            4'd3:  sh_inj_v    = v[0];
            4'd4:  sh_inj.last = v[0];
            4'd5:  sh_inj.keep = KW'(v);
            4'd6:  sh_inj.dest = DESTW'(v);
            4'd7:  sh_inj.id   = IDW'(v);
            4'd8:  sh_pause    = v[0];
            4'd9:  sh_kd       = v[0];
            4'd10: sh_kl       = v[0];
            default: ;
        endcase
    endtask

    // One clock of stimulus; model predicts the cycle's handshakes and updates itself
    task automatic step(input logic iv, input flit_t f, input logic ordy, input logic lrdy,
                        input logic cv, input logic [DW-1:0] cd);
        logic go_out, go_log, pend0, e_ir, e_ov, e_lv, do_commit;
        in_TVALID = iv;
        {in_TDATA, in_TKEEP, in_TLAST, in_TDEST, in_TID} = f;
        out_TREADY = ordy;
        log_catted_TREADY = lrdy;
        cmd_TVALID = cv;
        cmd_TDATA = cd;
        #1;
        go_out = !(a_kd || a_drop != '0);
        go_log = a_kl || a_log != '0;
        pend0  = m_pending;
        e_ir = 0; e_ov = 0; e_lv = 0;
        if (pend0) begin
            e_ov = 1;
        end else if (!a_pause) begin
            // A flit advances only when every destination it is bound for is ready
            e_ir = (!go_out || ordy) && (!go_log || lrdy);
            e_ov = iv && go_out && (!go_log || lrdy);
            e_lv = iv && go_log && (!go_out || ordy);
        end
        chk("in_TREADY", 128'(in_TREADY), 128'(e_ir));
        chk("out_TVALID", 128'(out_TVALID), 128'(e_ov));
        chk("log_TVALID", 128'(log_catted_TVALID), 128'(e_lv));
        chk("cmd_TREADY", 128'(cmd_TREADY), 128'(m_cmd_rdy));
        if (pend0 && ordy) m_pending = 0;
        if (!pend0 && !a_pause && iv && e_ir) begin
            if (go_out) exp_out.push_back(f);
            if (go_log) exp_log.push_back(f);
            if (a_drop != '0) a_drop = a_drop - CW'(1);
            if (a_log != '0)  a_log  = a_log - CW'(1);
        end
        do_commit = 0;
        if (cv && m_cmd_rdy) begin
            if (!m_expect_val) begin
                if (cd[3:0] == 4'd15) begin
                    do_commit = (cd[15:8] == ADDR);
                end else begin
                    m_expect_val = 1;
                    m_reg = cd[3:0];
                    m_match = (cd[15:8] == ADDR);
                end
            end else begin
                m_expect_val = 0;
                if (m_match) shadow_write(m_reg, cd);
            end
        end
        if (do_commit) begin
            a_drop = sh_drop; a_log = sh_log;
            a_pause = sh_pause; a_kd = sh_kd; a_kl = sh_kl;
            if (!pend0) begin
                a_inj = sh_inj;
                if (sh_inj_v) begin
                    m_pending = 1;
                    sh_inj_v = 0;
                    exp_out.push_back(a_inj);
                end
            end
        end
        @(posedge clk);
        #1;
        m_cmd_rdy = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 1, 1, 0, '0);
    endtask

    task automatic send_cmd(input logic [DW-1:0] w);
        step(0, '0, 1, 1, 1, w);
    endtask

    task automatic wr(input logic [7:0] a, input logic [3:0] r, input logic [DW-1:0] v);
        send_cmd(hdr(a, r));
        send_cmd(v);
    endtask

    task automatic commit(input logic [7:0] a);
        send_cmd(hdr(a, 4'd15));
    endtask

    task automatic send(input flit_t f);
        step(1, f, 1, 1, 0, '0);
    endtask

    task automatic rand_step();
        flit_t         f;
        logic [DW-1:0] cd;
        logic [7:0]    a;
        logic [3:0]    r;
        f = mk(DW'($urandom), KW'($urandom), 1'($urandom), DESTW'($urandom), IDW'($urandom));
        if (m_expect_val) begin
            cd = DW'($urandom);
            if (m_reg <= 4'd1) cd[CW-1:0] = CW'($urandom_range(0, 5));
        end else begin
            a  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : ADDR;
            r  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            cd = hdr(a, r);
        end
        step($urandom_range(0, 3) != 0, f, $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, cd);
    endtask

    // Monitor: every output handshake must match the head of its expected queue
    always @(negedge clk) begin
        if (!rst) begin
            if (out_TVALID && out_TREADY) begin
                if (exp_out.size() == 0) begin
                    chk("out_unexpected", 128'(out_TDATA), 128'(0));
                end else begin
                    mon_e = exp_out.pop_front();
                    chk("out_flit", 128'({out_TDATA, out_TKEEP, out_TLAST, out_TDEST, out_TID}),
                        128'(mon_e));
                end
            end
            if (log_catted_TVALID && log_catted_TREADY) begin
                if (exp_log.size() == 0) begin
                    chk("log_unexpected", 128'(log_catted_TDATA), 128'(0));
                end else begin
                    mon_e = exp_log.pop_front();
                    chk("log_flit", 128'(log_catted_TDATA), 128'(mon_e));
                    chk("log_TLAST", 128'(log_catted_TLAST), 128'(mon_e.last));
                end
            end
        end
    end

    initial begin
        rst = 1;
        cmd_TDATA = '0; cmd_TVALID = 0;
        in_TDATA = '0; in_TKEEP = '0; in_TDEST = '0; in_TID = '0; in_TLAST = 0; in_TVALID = 0;
        out_TREADY = 1; log_catted_TREADY = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cmd_TREADY", 128'(cmd_TREADY), 128'(0));
        chk("reset_out_TVALID", 128'(out_TVALID), 128'(0));
        chk("reset_log_TVALID", 128'(log_catted_TVALID), 128'(0));
        rst = 0;
        idle(2);

        // Transparent pass-through
        for (int i = 0; i < 4; i++) send(mk(DW'(32'hA1 + i), 4'hF, i == 3, 16'h1, 16'h2));

        // Drop two, then the counter stops at zero
        wr(ADDR, 4'd0, 32'hFFFF_0002);
        commit(ADDR);
        for (int i = 0; i < 4; i++) send(mk(DW'(32'hB1 + i), 4'hF, 0, 16'h0, 16'h0));
        for (int i = 0; i < 2; i++) send(mk(DW'(32'hB5 + i), 4'h3, 1, 16'h7, 16'h8));

        // Log three with a two-cycle log stall on the first
        wr(ADDR, 4'd0, 32'h0);
        wr(ADDR, 4'd1, 32'h3);
        commit(ADDR);
        step(1, mk(32'hC1, 4'hF, 0, 16'h0012, 16'h0034), 1, 0, 0, '0);
        step(1, mk(32'hC1, 4'hF, 0, 16'h0012, 16'h0034), 1, 0, 0, '0);
        for (int i = 0; i < 5; i++) send(mk(DW'(32'hC1 + i), 4'hF, i == 4, 16'h0012, 16'h0034));

        // Pause with a single injected flit
        wr(ADDR, 4'd1, 32'h0);
        wr(ADDR, 4'd8, 32'h1);
        wr(ADDR, 4'd2, 32'hDEADBEEF);
        wr(ADDR, 4'd4, 32'h1);
        wr(ADDR, 4'd3, 32'h1);
        commit(ADDR);
        for (int i = 0; i < 4; i++) send(mk(32'hE1, 4'hF, 0, 16'h0, 16'h0));
        wr(ADDR, 4'd8, 32'h0);
        commit(ADDR);
        for (int i = 0; i < 2; i++) send(mk(DW'(32'hE1 + i), 4'hF, 0, 16'h0, 16'h0));

        // Address mismatch: write and commit both ignored, decoder stays aligned
        wr(ADDR ^ 8'h01, 4'd0, 32'h5);
        commit(ADDR ^ 8'h01);
        commit(ADDR);
        for (int i = 0; i < 3; i++) send(mk(DW'(32'hF1 + i), 4'hF, 0, 16'h0, 16'h0));
        wr(ADDR, 4'd0, 32'h1);
        commit(ADDR);
        for (int i = 0; i < 2; i++) send(mk(DW'(32'hF4 + i), 4'hF, 0, 16'h0, 16'h0));

        // Commit of drop_cnt=1 on the same cycle as an in handshake with drop_cnt=3
        wr(ADDR, 4'd0, 32'h3);
        commit(ADDR);
        wr(ADDR, 4'd0, 32'h1);
        step(1, mk(32'h91, 4'hF, 0, 16'h0, 16'h0), 1, 1, 1, hdr(ADDR, 4'd15));
        for (int i = 0; i < 3; i++) send(mk(DW'(32'h92 + i), 4'hF, 0, 16'h0, 16'h0));

        // Randomized traffic interleaved with commands
        for (int i = 0; i < 800; i++) rand_step();
        wr(ADDR, 4'd8, 32'h0);
        wr(ADDR, 4'd9, 32'h0);
        wr(ADDR, 4'd10, 32'h0);
        wr(ADDR, 4'd3, 32'h0);
        commit(ADDR);
        idle(3);
        chk("out_queue_drained", 128'(exp_out.size()), 128'(0));
        chk("log_queue_drained", 128'(exp_log.size()), 128'(0));

        // Reset while the decoder waits for a value and an injection is held off
        wr(ADDR, 4'd2, 32'h12345678);
        wr(ADDR, 4'd3, 32'h1);
        wr(ADDR, 4'd0, 32'h4);
        commit(ADDR);
        step(0, '0, 0, 1, 1, hdr(ADDR, 4'd1));
        rst = 1;
        in_TVALID = 0;
        cmd_TVALID = 0;
        #1;
        chk("midrst_cmd_TREADY", 128'(cmd_TREADY), 128'(0));
        chk("midrst_out_TVALID", 128'(out_TVALID), 128'(0));
        chk("midrst_log_TVALID", 128'(log_catted_TVALID), 128'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        idle(2);
        for (int i = 0; i < 3; i++) send(mk(DW'(32'h71 + i), 4'hF, 0, 16'h3, 16'h4));
        commit(ADDR);
        for (int i = 0; i < 2; i++) send(mk(DW'(32'h81 + i), 4'hF, 0, 16'h3, 16'h4));
        idle(2);
        chk("final_out_queue", 128'(exp_out.size()), 128'(0));
        chk("final_log_queue", 128'(exp_log.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
